// File: rtl/pwm_deadtime_modulator_pkg.sv
// Shared definitions for the PWM dead-time modulator: gate FSM encoding,
// dead-time counter limits and small helpers used at elaboration and runtime.
package pwm_deadtime_modulator_pkg;

    localparam int DEAD_MIN = 1;
    localparam int DEAD_MAX = 255;
    localparam int DT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_DT  = 2'd1,
        ST_HI  = 2'd2,
        ST_LO  = 2'd3
    } dt_state_e;

    // Counter reload for a dead time of 'cycles' clocks, held inside the legal range.
    function automatic logic [DT_CNT_W-1:0] dead_reload(input int cycles);
        int c;
        c = (cycles < DEAD_MIN) ? DEAD_MIN : ((cycles > DEAD_MAX) ? DEAD_MAX : cycles);
        return DT_CNT_W'(c - 1);
    endfunction

    // Gate drive pair {hi, lo} for a given FSM state.
    function automatic logic [1:0] gate_drive(input dt_state_e s);
        case (s)
            ST_HI:   return 2'b10;
            ST_LO:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/pwm_deadtime_modulator_deadtime_gen.sv
// Dead-time gate FSM: turns the raw compare bit into complementary gate drives
// separated by a fixed number of (0,0) clocks.
module deadtime_gen
    import pwm_deadtime_modulator_pkg::*;
#(
    parameter logic [DT_CNT_W-1:0] RELOAD = 8'd7
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic raw_q,
    input  logic enable,
    output logic pwm_hi,
    output logic pwm_lo
);

    dt_state_e           state_reg, state_next;
    logic [DT_CNT_W-1:0] cnt_reg, cnt_next;
    logic                pwm_hi_reg, pwm_lo_reg;
    logic [1:0]          drive_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_OFF;
            cnt_reg    <= '0;
            pwm_hi_reg <= 1'b0;
            pwm_lo_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            pwm_hi_reg <= drive_next[1];
            pwm_lo_reg <= drive_next[0];
        end
    end

    // Drives are decoded from the next state so they register alongside it.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (!enable) begin
            state_next = ST_OFF;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    state_next = ST_DT;
                    cnt_next   = RELOAD;
                end
                ST_DT: begin
                    if (cnt_reg == '0) begin
                        state_next = raw_q ? ST_HI : ST_LO;
                    end else begin
                        cnt_next = cnt_reg - DT_CNT_W'(1);
                    end
                end
                ST_HI: begin
                    if (!raw_q) begin
                        state_next = ST_DT;
                        cnt_next   = RELOAD;
                    end
                end
                ST_LO: begin
                    if (raw_q) begin
                        state_next = ST_DT;
                        cnt_next   = RELOAD;
                    end
                end
                default: state_next = ST_OFF;
            endcase
        end
        drive_next = gate_drive(state_next);
    end

    assign pwm_hi = pwm_hi_reg;
    assign pwm_lo = pwm_lo_reg;

endmodule

// File: rtl/pwm_deadtime_modulator.sv
// Carrier-compare PWM with valley-synchronised duty update, command clamping
// and a dead-time gate stage.
module pwm_deadtime_modulator
    import pwm_deadtime_modulator_pkg::*;
#(
    parameter int CNT_MAX     = 2500,
    parameter int DEAD_CYCLES = 8,
    parameter int DATA_W      = 32
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] carrier,
    input  logic signed [DATA_W-1:0] duty_cmd,
    input  logic                     duty_valid,
    input  logic                     enable,
    output logic                     pwm_hi,
    output logic                     pwm_lo,
    output logic                     update_ack,
    output logic                     sat
);

    localparam logic signed [DATA_W-1:0] DUTY_MAX  = DATA_W'(CNT_MAX);
    localparam logic signed [DATA_W-1:0] DUTY_MIN  = DATA_W'(-CNT_MAX);
    localparam logic [DT_CNT_W-1:0]      DT_RELOAD = dead_reload(DEAD_CYCLES);

    logic signed [DATA_W-1:0] shadow_reg, active_reg, duty_clamped;
    logic                     pending_reg, ack_reg, sat_reg, raw_q;
    logic                     cmd_over, valley, apply;

    always_comb begin
        duty_clamped = duty_cmd;
        cmd_over     = 1'b0;
        if (duty_cmd > DUTY_MAX) begin
            duty_clamped = DUTY_MAX;
            cmd_over     = 1'b1;
        end else if (duty_cmd < DUTY_MIN) begin
            duty_clamped = DUTY_MIN;
            cmd_over     = 1'b1;
        end
    end

    assign valley = (carrier <= DUTY_MIN);
    assign apply  = valley && pending_reg;

    // A command arriving on a valley edge stays pending; the older shadow is applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg  <= '0;
            active_reg  <= '0;
            pending_reg <= 1'b0;
            ack_reg     <= 1'b0;
            sat_reg     <= 1'b0;
            raw_q       <= 1'b0;
        end else begin
            raw_q   <= (carrier < active_reg);
            ack_reg <= apply;
            if (apply) begin
                active_reg <= shadow_reg;
            end
            if (duty_valid) begin
                shadow_reg  <= duty_clamped;
                pending_reg <= 1'b1;
                sat_reg     <= cmd_over;
            end else if (apply) begin
                pending_reg <= 1'b0;
            end
        end
    end

    deadtime_gen #(
        .RELOAD (DT_RELOAD)
    ) u_deadtime_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_q  (raw_q),
        .enable (enable),
        .pwm_hi (pwm_hi),
        .pwm_lo (pwm_lo)
    );

    assign update_ack = ack_reg;
    assign sat        = sat_reg;

endmodule

// File: tb/tb_pwm_deadtime_modulator.sv
// Self-checking bench: triangular carrier, directed and random duty commands,
// compared every cycle against a timestamp-based behavioural model.
module tb_pwm_deadtime_modulator;

    localparam int CNT_MAX = 2500;
    localparam int D       = 8;
    localparam int STEP    = 50;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [31:0] carrier = '0;
    logic signed [31:0] duty_cmd = '0;
    logic               duty_valid = 1'b0;
    logic               enable = 1'b0;
    logic               pwm_hi, pwm_lo, update_ack, sat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pwm_deadtime_modulator #(
        .CNT_MAX     (CNT_MAX),
        .DEAD_CYCLES (D),
        .DATA_W      (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .carrier    (carrier),
        .duty_cmd   (duty_cmd),
        .duty_valid (duty_valid),
        .enable     (enable),
        .pwm_hi     (pwm_hi),
        .pwm_lo     (pwm_lo),
        .update_ack (update_ack),
        .sat        (sat)
    );

    assert property (@(negedge clk) !(pwm_hi && pwm_lo))
        else $error("FAIL overlap: pwm_hi=%0b pwm_lo=%0b", pwm_hi, pwm_lo);

    // Triangular carrier source
    int tri_val = -CNT_MAX;
    int tri_dir = 1;
    bit tri_on  = 1'b1;
    int cyc     = 0;

    // Behavioural model: duty pipeline plus a dead window [dt_start, dt_start+D)
    int m_shadow, m_active, m_edge, m_dt_start, m_side;
    bit m_pending, m_sat, m_ack, m_raw, m_run;

    // Observation counters
    int hi_cnt, lo_cnt, zero_cnt, zero_run, last_side;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_shadow = 0; m_active = 0; m_pending = 0; m_sat = 0; m_ack = 0; m_raw = 0;
        m_run = 0; m_side = 0; m_dt_start = 0;
    endtask

    task automatic model_step();
        int  c, d;
        bit  valley, apply;
        if (!rst_n) begin
            model_reset();
            return;
        end
        c      = carrier;
        valley = (c <= -CNT_MAX);
        apply  = valley && m_pending;
        m_edge++;
        if (!enable) begin
            m_run = 0; m_side = 0;
        end else if (!m_run) begin
            m_run = 1; m_side = 0; m_dt_start = m_edge;
        end else if (m_side == 0) begin
            if (m_edge - m_dt_start >= D) m_side = m_raw ? 1 : 2;
        end else if ((m_side == 1) != m_raw) begin
            m_side = 0; m_dt_start = m_edge;
        end
        m_raw = (c < m_active);
        m_ack = apply;
        if (apply) m_active = m_shadow;
        if (duty_valid) begin
            d         = duty_cmd;
            m_sat     = (d > CNT_MAX) || (d < -CNT_MAX);
            m_shadow  = (d > CNT_MAX) ? CNT_MAX : ((d < -CNT_MAX) ? -CNT_MAX : d);
            m_pending = 1;
        end else if (apply) begin
            m_pending = 0;
        end
    endtask

    task automatic compare();
        int cur;
        check("outputs{hi,lo,ack,sat}", {pwm_hi, pwm_lo, update_ack, sat},
              {(m_side == 1), (m_side == 2), m_ack, m_sat});
        check("no_overlap", pwm_hi & pwm_lo, 0);
        if (pwm_hi) hi_cnt++;
        if (pwm_lo) lo_cnt++;
        if (!pwm_hi && !pwm_lo) begin
            zero_cnt++;
            zero_run++;
        end else begin
            cur = pwm_hi ? 1 : 2;
            if (zero_run > 0) check("dead_gap_len", zero_run >= D, 1);
            else if (last_side != 0 && last_side != cur) check("side_change_without_dead", cur, last_side);
            zero_run  = 0;
            last_side = cur;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic drive_cycle(input bit strobe, input int cmd);
        if (tri_on) begin
            carrier = tri_val;
            if (tri_val >= CNT_MAX) tri_dir = -1;
            else if (tri_val <= -CNT_MAX) tri_dir = 1;
            tri_val += tri_dir * STEP;
        end
        duty_valid = strobe;
        duty_cmd   = cmd;
        if (strobe) $display("cycle %0d: duty_cmd %0d carrier %0d", cyc, cmd, carrier);
        cycle();
        duty_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 0);
    endtask

    task automatic clear_counts();
        hi_cnt = 0; lo_cnt = 0; zero_cnt = 0;
    endtask

    // Runs until update_ack is seen; the carrier of that cycle's edge must be the valley.
    task automatic wait_ack(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            drive_cycle(1'b0, 0);
            if (update_ack) begin
                found = 1;
                check({name, "_ack_at_valley"}, carrier, -CNT_MAX);
            end
        end
        if (!found) check({name, "_ack_timeout"}, 0, 1);
    endtask

    task automatic strobe_peak(input int cmd);
        int guard;
        guard = 0;
        while (tri_val != CNT_MAX && guard < 400) begin
            drive_cycle(1'b0, 0);
            guard++;
        end
        drive_cycle(1'b1, cmd);
    endtask

    initial begin
        model_reset();
        m_edge = 0; zero_run = 0; last_side = 0;
        clear_counts();
        repeat (3) @(negedge clk);
        check("reset_hi", pwm_hi, 0);
        check("reset_lo", pwm_lo, 0);
        check("reset_ack", update_ack, 0);
        check("reset_sat", sat, 0);
        rst_n = 1'b1;

        // 50 % duty with zero command, exact dead time after enable
        enable = 1'b1;
        clear_counts();
        run(D);
        check("first_dead_zero_cycles", zero_cnt, D);
        run(1);
        check("on_after_dead", pwm_hi | pwm_lo, 1);
        run(600);
        clear_counts();
        run(200);
        check("duty0_hi_cycles", hi_cnt, 91);
        check("duty0_lo_cycles", lo_cnt, 93);

        // Mid-period update to 1000
        strobe_peak(1000);
        wait_ack("duty1000");
        clear_counts();
        run(200);
        check("duty1000_hi_cycles", hi_cnt, 131);

        // Saturation both ways
        drive_cycle(1'b1, 4000);
        check("sat_pos", sat, 1);
        wait_ack("duty_pos");
        clear_counts();
        run(200);
        check("duty_max_hi_cycles", hi_cnt, 192);
        drive_cycle(1'b1, -4000);
        check("sat_neg", sat, 1);
        wait_ack("duty_neg");
        run(20);
        clear_counts();
        run(200);
        check("duty_min_lo_cycles", lo_cnt, 200);

        // Short raw glitch while in HI is absorbed by the dead time
        drive_cycle(1'b1, 0);
        wait_ack("duty_zero");
        tri_on  = 1'b0;
        carrier = -1000;
        run(30);
        check("glitch_pre_hi", pwm_hi, 1);
        clear_counts();
        carrier = 1000;
        run(3);
        carrier = -1000;
        run(27);
        check("glitch_dead_cycles", zero_cnt, D);
        check("glitch_no_lo", lo_cnt, 0);
        check("glitch_back_hi", pwm_hi, 1);

        // Asynchronous reset while in HI
        #2 rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check("async_rst_hi", pwm_hi, 0);
        check("async_rst_lo", pwm_lo, 0);
        model_reset();
        run(2);
        rst_n = 1'b1;
        run(5);
        check("idle_after_reset", pwm_hi | pwm_lo, 0);

        // Enable drop while in LO
        enable  = 1'b1;
        carrier = 1000;
        run(30);
        check("lo_before_disable", pwm_lo, 1);
        enable = 1'b0;
        run(1);
        check("disable_lo_off", pwm_lo, 0);
        check("disable_hi_off", pwm_hi, 0);
        enable = 1'b1;

        // Randomized commands, valley coincidences and enable drops
        tri_on  = 1'b1;
        tri_val = -CNT_MAX;
        tri_dir = 1;
        for (int i = 0; i < 3000; i++) begin
            bit strobe;
            strobe = ($urandom_range(0, 49) == 0) ||
                     (tri_val == -CNT_MAX && $urandom_range(0, 1) == 1);
            if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
            drive_cycle(strobe, int'($urandom_range(0, 8000)) - 4000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
